// File: rtl/perceptron_trainer_if.sv
// Bundle between the forward path and the perceptron weight bank / learning-rule engine.
// master drives requests and loads; slave owns the weights and reports busy/done/sat.
interface perceptron_trainer_if #(
  parameter int N     = 4,
  parameter int WIDTH = 6
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  logic                    start;
  logic                    target;
  logic                    predicted;
  logic signed [WIDTH-1:0] lr;
  logic [N*WIDTH-1:0]      x_flat;
  logic                    load_en;
  logic [IDXW-1:0]         load_idx;
  logic signed [WIDTH-1:0] load_data;
  logic [N*WIDTH-1:0]      w_flat;
  logic                    busy;
  logic                    done;
  logic                    sat;

  modport master (
    output start, target, predicted, lr, x_flat, load_en, load_idx, load_data,
    input  w_flat, busy, done, sat
  );

  modport slave (
    input  start, target, predicted, lr, x_flat, load_en, load_idx, load_data,
    output w_flat, busy, done, sat
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Weight bank + perceptron rule w[i] <= sat(w[i] + err*lr*x[i]), one weight per cycle.
// Latency N+1 cycles start-to-done (1 when err = 0); start/load are dropped while busy, no queuing.
module perceptron_trainer #(
  parameter int N     = 4,
  parameter int WIDTH = 6,
  parameter int FRAC  = 3
) (
  input logic                 clk,
  input logic                 reset_l,
  perceptron_trainer_if.slave bus
);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic signed [WIDTH-1:0] lr_q, lr_d;
  logic                    err_neg_q, err_neg_d;
  logic                    sat_q, sat_d;
  logic                    busy_q, done_q;
  logic [WIDTH-1:0]        w_q [N];
  logic [WIDTH-1:0]        w_d [N];

  logic signed [WIDTH-1:0]   x_cur, w_cur, q_sat, s_sat;
  logic signed [2*WIDTH-1:0] prod, q_full;
  logic signed [WIDTH:0]     s_full;
  logic                      q_clip, s_clip;

  // Datapath for the weight currently addressed by idx_q.
  always_comb begin
    x_cur  = bus.x_flat[idx_q*WIDTH +: WIDTH];
    w_cur  = w_q[idx_q];
    prod   = $signed({{WIDTH{lr_q[WIDTH-1]}}, lr_q}) * $signed({{WIDTH{x_cur[WIDTH-1]}}, x_cur});
    q_full = prod >>> FRAC;
    q_clip = (q_full[2*WIDTH-1:WIDTH-1] != '0) && (q_full[2*WIDTH-1:WIDTH-1] != '1);
    q_sat  = q_clip ? (q_full[2*WIDTH-1] ? SMIN : SMAX) : q_full[WIDTH-1:0];
    s_full = err_neg_q ? ({w_cur[WIDTH-1], w_cur} - {q_sat[WIDTH-1], q_sat})
                       : ({w_cur[WIDTH-1], w_cur} + {q_sat[WIDTH-1], q_sat});
    s_clip = s_full[WIDTH] != s_full[WIDTH-1];
    s_sat  = s_clip ? (s_full[WIDTH] ? SMIN : SMAX) : s_full[WIDTH-1:0];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lr_d      = lr_q;
    err_neg_d = err_neg_q;
    sat_d     = sat_q;
    w_d       = w_q;
    case (state_q)
      IDLE: begin
        // start has priority; a simultaneous load is dropped.
        if (bus.start) begin
          lr_d      = bus.lr;
          err_neg_d = !bus.target && bus.predicted;
          sat_d     = 1'b0;
          idx_d     = '0;
          state_d   = (bus.target != bus.predicted) ? UPDATE : DONE;
        end else if (bus.load_en && (int'(bus.load_idx) < N)) begin
          w_d[bus.load_idx] = bus.load_data;
        end
      end
      UPDATE: begin
        w_d[idx_q] = s_sat;
        if (q_clip || s_clip) sat_d = 1'b1;
        if (idx_q == IDXW'(N-1)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lr_q      <= '0;
      err_neg_q <= 1'b0;
      sat_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < N; i++) w_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lr_q      <= lr_d;
      err_neg_q <= err_neg_d;
      sat_q     <= sat_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      w_q       <= w_d;
    end
  end

  always_comb begin
    bus.w_flat = '0;
    for (int i = 0; i < N; i++) bus.w_flat[i*WIDTH +: WIDTH] = w_q[i];
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sat  = sat_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: directed cases with literal expectations, then random traffic
// compared every cycle against an integer-arithmetic reference model.
module tb_perceptron_trainer;
  localparam int N = 4;
  localparam int W = 6;

  logic clk = 1'b0;
  logic reset_l;
  always #5 clk = ~clk;

  perceptron_trainer_if #(.N(N), .WIDTH(W)) bus ();
  perceptron_trainer #(.N(N), .WIDTH(W), .FRAC(3)) dut (
    .clk    (clk),
    .reset_l(reset_l),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int wsl(input logic [N*W-1:0] v, input int i);
    return int'($signed(v[i*W +: W]));
  endfunction

  function automatic logic [N*W-1:0] packx(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  function automatic int clamp(input int v, inout bit clipped);
    if (v > 31)  begin clipped = 1'b1; return 31;  end
    if (v < -32) begin clipped = 1'b1; return -32; end
    return v;
  endfunction

  // Reference model: integer arithmetic, mk = next weight to update, mk == N means done phase.
  int mw [N];
  bit mbusy, mdone, msat;
  int mk, merr, mlr;

  always @(posedge clk or negedge reset_l) begin
    int xi, q, s;
    if (!reset_l) begin
      for (int i = 0; i < N; i++) mw[i] = 0;
      mbusy = 1'b0; mdone = 1'b0; msat = 1'b0; mk = 0; merr = 0; mlr = 0;
    end else if (!mbusy) begin
      if (bus.start) begin
        merr  = int'(bus.target) - int'(bus.predicted);
        mlr   = int'($signed(bus.lr));
        msat  = 1'b0;
        mbusy = 1'b1;
        mk    = (merr == 0) ? N : 0;
        mdone = (merr == 0);
      end else if (bus.load_en) begin
        mw[bus.load_idx] = int'($signed(bus.load_data));
      end
    end else if (mk < N) begin
      xi     = int'($signed(bus.x_flat[mk*W +: W]));
      q      = clamp((mlr * xi) >>> 3, msat);
      s      = (merr > 0) ? mw[mk] + q : mw[mk] - q;
      mw[mk] = clamp(s, msat);
      mk++;
      mdone  = (mk == N);
    end else begin
      mbusy = 1'b0;
      mdone = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [N*W-1:0] ew;
    if (check_en) begin
      for (int i = 0; i < N; i++) ew[i*W +: W] = W'(mw[i]);
      n_checks++;
      if ({bus.w_flat, bus.busy, bus.done, bus.sat} !== {ew, mbusy, mdone, msat}) begin
        n_errors++;
        $display("FAIL cycle_compare @%0t: got w=%h busy=%b done=%b sat=%b expected w=%h busy=%b done=%b sat=%b",
                 $time, bus.w_flat, bus.busy, bus.done, bus.sat, ew, mbusy, mdone, msat);
      end
    end
  end

  task automatic wait_idle(output int busy_cyc, output int done_at);
    busy_cyc = 0;
    done_at  = -1;
    while (bus.busy && busy_cyc < 40) begin
      busy_cyc++;
      if (bus.done) done_at = busy_cyc;
      @(negedge clk);
    end
    chk("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic start_upd(input logic [N*W-1:0] xf, input int lrv, input bit t, input bit y);
    @(negedge clk);
    bus.x_flat = xf; bus.lr = W'(lrv); bus.target = t; bus.predicted = y; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_load(input int idx, input int val);
    @(negedge clk);
    bus.load_en = 1'b1; bus.load_idx = 2'(idx); bus.load_data = W'(val);
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic chk_w(input string nm, input int a, input int b, input int c, input int d);
    chk({nm, "_w0"}, wsl(bus.w_flat, 0), a);
    chk({nm, "_w1"}, wsl(bus.w_flat, 1), b);
    chk({nm, "_w2"}, wsl(bus.w_flat, 2), c);
    chk({nm, "_w3"}, wsl(bus.w_flat, 3), d);
  endtask

  initial begin
    int bc, da;
    reset_l = 1'b0;
    bus.start = 1'b0; bus.target = 1'b0; bus.predicted = 1'b0; bus.lr = '0;
    bus.x_flat = '0; bus.load_en = 1'b0; bus.load_idx = '0; bus.load_data = '0;
    @(negedge clk);
    chk("rst_w", int'(bus.w_flat), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_sat", int'(bus.sat), 0);
    @(negedge clk);
    reset_l  = 1'b1;
    check_en = 1'b1;

    start_upd(packx(8, 16, -8, 0), 4, 1'b1, 1'b0);
    wait_idle(bc, da);
    chk_w("basic", 4, 8, -4, 0);
    chk("basic_busy_cycles", bc, 5);
    chk("basic_done_cycle", da, 5);
    chk("basic_sat", int'(bus.sat), 0);

    for (int i = 0; i < N; i++) do_load(i, 0);
    start_upd(packx(-1, 1, 0, 0), 1, 1'b0, 1'b1);
    wait_idle(bc, da);
    chk_w("negerr", 1, 0, 0, 0);
    chk("negerr_sat", int'(bus.sat), 0);

    do_load(0, 28);
    start_upd(packx(24, 0, 0, 0), 8, 1'b1, 1'b0);
    wait_idle(bc, da);
    chk_w("sat1", 31, 0, 0, 0);
    chk("sat1_sat", int'(bus.sat), 1);

    do_load(0, 0);
    start_upd(packx(-32, 0, 0, 0), 31, 1'b1, 1'b0);
    wait_idle(bc, da);
    chk_w("sat2", -32, 0, 0, 0);
    chk("sat2_sat", int'(bus.sat), 1);

    start_upd(packx(-32, 0, 0, 0), 5, 1'b1, 1'b1);
    wait_idle(bc, da);
    chk("zero_busy_cycles", bc, 1);
    chk("zero_done_cycle", da, 1);
    chk("zero_sat", int'(bus.sat), 0);
    chk_w("zero", -32, 0, 0, 0);

    for (int i = 0; i < N; i++) do_load(i, 0);
    start_upd(packx(8, 16, -8, 0), 4, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.load_en = 1'b1; bus.load_idx = 2'd0; bus.load_data = W'(5);
    @(negedge clk);
    bus.start = 1'b0; bus.load_en = 1'b0;
    wait_idle(bc, da);
    chk_w("robust", 4, 8, -4, 0);
    chk("robust_sat", int'(bus.sat), 0);

    start_upd(packx(8, 16, -8, 0), 4, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("prerst_w0", wsl(bus.w_flat, 0), 8);
    #1;
    reset_l = 1'b0;
    #1;
    chk("midrst_w", int'(bus.w_flat), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    @(negedge clk);
    reset_l = 1'b1;

    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: do_load(int'($urandom_range(0, N-1)), int'($signed(W'($urandom_range(0, 63)))));
        1, 2: begin
          @(negedge clk);
          bus.x_flat    = (N*W)'({$urandom, $urandom});
          bus.lr        = W'($urandom_range(0, 63));
          bus.target    = 1'($urandom_range(0, 1));
          bus.predicted = 1'($urandom_range(0, 1));
          bus.load_en   = 1'($urandom_range(0, 1));
          bus.load_idx  = 2'($urandom_range(0, N-1));
          bus.load_data = W'($urandom_range(0, 63));
          bus.start     = 1'b1;
          @(negedge clk);
          bus.start = 1'b0; bus.load_en = 1'b0;
          wait_idle(bc, da);
        end
        default: begin
          @(negedge clk);
          bus.x_flat    = (N*W)'({$urandom, $urandom});
          bus.lr        = W'($urandom_range(0, 63));
          bus.target    = 1'($urandom_range(0, 1));
          bus.predicted = 1'($urandom_range(0, 1));
          bus.start     = 1'b1;
          repeat ($urandom_range(5, 15)) @(negedge clk);
          bus.start = 1'b0;
          wait_idle(bc, da);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/perceptron_trainer.md
# perceptron_trainer

Weight bank and learning-rule engine for the perceptron core. It owns the N signed 6-bit weights, which the forward path reads continuously. After each forward inference it applies w[i] <= sat(w[i] + err*lr*x[i]) sequentially, one weight per cycle. The forward path computes y = f(Σ w·x); this block runs the opposite direction, feeding the error back into the weights.

## Interface
- N, default 4: number of weights; bias is handled by the caller supplying x = 1.0 at some index.
- WIDTH, default 6: data width of weights, inputs and lr. All are two's complement.
- FRAC, default 3: fractional bits. With defaults the format is Q3.3 (1.0 = 8, range −4.0 to +3.875).
- clk  in  1  clock, rising-edge.
- reset_l  in  1  reset, asynchronous, active-low.
- start  in  1  request an update; sampled only in IDLE.
- target  in  1  desired class t ∈ {0,1}; latched on start.
- predicted  in  1  forward-path output y ∈ {0,1}; latched on start.
- lr  in  WIDTH  signed learning rate; latched on start.
- x_flat  in  N*WIDTH  input vector, x[i] = x_flat[i*WIDTH +: WIDTH]; must be held stable from start through done.
- load_en  in  1  write one weight directly; honored only in IDLE.
- load_idx  in  $clog2(N)  weight index for load.
- load_data  in  WIDTH  weight value for load.
- w_flat  out  N*WIDTH  current weights, registered, same packing as x_flat.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  single-cycle pulse when an update completes.
- sat  out  1  sticky flag: some saturation occurred during the last update; cleared on accepted start.

## Operation
- States: IDLE, UPDATE, DONE.
- Error is err = t − y, taking values in {−1, 0, +1}.
- IDLE, start=1 at an edge:
  - latch t, y and lr; clear sat; set idx = 0.
  - err ≠ 0 → go to UPDATE.
  - err = 0 → go straight to DONE; no weight is written.
- UPDATE, each edge, for idx = 0..N−1:
  - p = lr * x[idx], full signed 2*WIDTH-bit product.
  - q = p >>> FRAC (arithmetic shift; truncates toward −∞). Saturate q to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - s = w[idx] + q if err = +1, or w[idx] − q if err = −1. Compute s at WIDTH+1 bits, then saturate to the same range.
  - write w[idx] <= s. If either saturation clipped, set sat.
  - idx increments; after the write for idx = N−1, go to DONE.
- DONE: done = 1 for exactly this cycle, then go to IDLE.
- Direct load: load_en=1 in IDLE writes w[load_idx] <= load_data at the edge.
  - load_idx ≥ N is ignored.
  - If start and load_en are both high in IDLE, start wins and the load is dropped.
- start and load_en are ignored while busy. There is no queuing.
- Reset, asserted at any time including mid-update: all weights = 0, state = IDLE, idx = 0, busy = 0, done = 0, sat = 0. The update is abandoned, and weights already written are also cleared.

## Timing
- Let E0 be the edge at which start is accepted.
- err ≠ 0:
  - busy is high from after E0 to after E(N+1).
  - w[k] is updated at edge E(k+1) and visible on w_flat in the following cycle.
  - done is high in the cycle between E(N) and E(N+1).
  - Total latency is N+1 cycles start-to-done; the next start is accepted at E(N+2) or later.
- err = 0: done is high in the cycle between E0 and E1; busy is high only in that cycle.
- w_flat, busy, done and sat are all driven from flops; there is no combinational path from inputs to outputs.
- Back-to-back: start held high through DONE is re-accepted at the first edge in IDLE.

## Test plan
- **Basic update.** Reset, then weights = 0, x = [8, 16, −8, 0], lr = 4, t = 1, y = 0, pulse start.
  - Required: w = [4, 8, −4, 0].
  - Required: done high exactly in the cycle after E4; sat = 0; busy high 5 cycles.
- **Negative error and truncation.** Load w = [0, 0, 0, 0], x = [−1, 1, 0, 0], lr = 1, t = 0, y = 1.
  - q = [−1, 0, 0, 0], giving w = [1, 0, 0, 0]; sat = 0.
- **Saturation.** First case: load w0 = 28, x0 = 24, lr = 8, err = +1.
  - Required: w0 = 31, sat = 1.
- **Saturation, second case.** Separate run: lr = 31, x0 = −32, err = +1, w0 = 0.
  - Required: q clips to −32, w0 = −32, sat = 1.
- **Zero error.** t = y = 1, start.
  - Required: done pulses in the cycle after E0; w_flat unchanged; sat cleared to 0.
- **Robustness.**
  - During UPDATE, pulse start and load_en (load_idx = 0, load_data = 5): both ignored, final weights match the basic case.
  - Assert reset_l low mid-UPDATE (after E2): w_flat = 0, busy = 0, done = 0 immediately (asynchronous).
